// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter, sequences fetch, handles stalls,
// absolute/relative branches and call/return through a small return stack.
// Reaching the end of the address space halts the core; stack misuse faults it.
module pc_sequencer #(
    parameter int D     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    input  logic         br_en,
    input  logic         br_rel,
    input  logic [D-1:0] target,
    input  logic         call_en,
    input  logic         ret_en,
    input  logic         halt_req,
    output logic [D-1:0] prog_ctr,
    output logic         running,
    output logic         done,
    output logic         stk_err
);

    // The stack pointer must count 0..DEPTH inclusive, so it needs one extra value.
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
    localparam logic [D-1:0]   PC_LAST = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT,
        FAULT
    } state_t;

    state_t         state_q, state_d;
    logic [D-1:0]   pc_q, pc_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [D-1:0]   stack_q [DEPTH];

    logic           pushEn;
    logic [D-1:0]   pushData;
    logic [IW-1:0]  wrIdx;
    logic [IW-1:0]  rdIdx;

    // Push writes the slot the pointer names; pop reads the slot just below it.
    assign wrIdx = IW'(sp_q);
    assign rdIdx = IW'(sp_q - SPW'(1));

    // Next-state logic: restart from HALT/FAULT/IDLE, otherwise one prioritised action per RUN cycle.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        sp_d     = sp_q;
        pushEn   = 1'b0;
        pushData = pc_q + D'(1);
        case (state_q)
            IDLE, HALT, FAULT: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = '0;
                    sp_d    = '0;
                end
            end
            RUN: begin
                if (stall) begin
                    state_d = RUN;
                end else if (halt_req) begin
                    state_d = HALT;
                end else if (ret_en) begin
                    if (sp_q == '0) begin
                        state_d = FAULT;
                    end else begin
                        pc_d = stack_q[rdIdx];
                        sp_d = sp_q - SPW'(1);
                    end
                end else if (call_en) begin
                    if (sp_q == SP_FULL) begin
                        state_d = FAULT;
                    end else begin
                        pushEn = 1'b1;
                        pc_d   = target;
                        sp_d   = sp_q + SPW'(1);
                    end
                end else if (br_en) begin
                    pc_d = br_rel ? (pc_q + target) : target;
                end else if (pc_q == PC_LAST) begin
                    state_d = HALT;
                end else begin
                    pc_d = pc_q + D'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = '0;
                sp_d    = '0;
            end
        endcase
    end

    // State, program counter and stack pointer registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            sp_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
        end
    end

    // Return-address storage; entries above the pointer are never read, so no reset is needed.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            stack_q[wrIdx] <= pushData;
        end
    end

    assign prog_ctr = pc_q;
    assign running  = (state_q == RUN);
    assign done     = (state_q == HALT) || (state_q == FAULT);
    assign stk_err  = (state_q == FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus randomized requests, checked every
// cycle against a queue-based behavioural model of the sequencer.
module tb_pc_sequencer;

    localparam int D     = 10;
    localparam int DEPTH = 4;
    localparam int M     = 1 << D;

    logic         clk;
    logic         reset;
    logic         startI;
    logic         stallI;
    logic         brEnI;
    logic         brRelI;
    logic [D-1:0] targetI;
    logic         callEnI;
    logic         retEnI;
    logic         haltReqI;
    logic [D-1:0] progCtr;
    logic         runningO;
    logic         doneO;
    logic         stkErrO;

    int checks;
    int passes;
    bit checkEn;

    // Model state: mode 0=idle 1=run 2=halt 3=fault, PC as an integer, stack as a queue.
    int mMode;
    int mPc;
    int mStack[$];

    pc_sequencer #(.D(D), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (startI),
        .stall    (stallI),
        .br_en    (brEnI),
        .br_rel   (brRelI),
        .target   (targetI),
        .call_en  (callEnI),
        .ret_en   (retEnI),
        .halt_req (haltReqI),
        .prog_ctr (progCtr),
        .running  (runningO),
        .done     (doneO),
        .stk_err  (stkErrO)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compareVal(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mMode = 0;
        mPc   = 0;
        mStack.delete();
    endtask

    // Applies the rules to the inputs sampled at this edge.
    task automatic modelUpdate();
        if (startI && mMode != 1) begin
            mMode = 1;
            mPc   = 0;
            mStack.delete();
        end else if (mMode == 1 && !stallI) begin
            if (haltReqI) begin
                mMode = 2;
            end else if (retEnI) begin
                if (mStack.size() == 0) mMode = 3;
                else mPc = mStack.pop_back();
            end else if (callEnI) begin
                if (mStack.size() == DEPTH) begin
                    mMode = 3;
                end else begin
                    mStack.push_back((mPc + 1) % M);
                    mPc = int'(targetI);
                end
            end else if (brEnI) begin
                mPc = brRelI ? (mPc + int'(targetI)) % M : int'(targetI);
            end else if (mPc == M - 1) begin
                mMode = 2;
            end else begin
                mPc = mPc + 1;
            end
        end
    endtask

    task automatic checkOutput();
        compareVal("prog_ctr", int'(progCtr), mPc);
        compareVal("running", int'(runningO), int'(mMode == 1));
        compareVal("done", int'(doneO), int'(mMode >= 2));
        compareVal("stk_err", int'(stkErrO), int'(mMode == 3));
    endtask

    // Compare process: outputs are checked against the model on every falling edge.
    always @(negedge clk) begin
        if (checkEn && !reset) checkOutput();
    end

    task automatic applyStimulus(input logic s, input logic st, input logic br, input logic rel,
                                 input logic [D-1:0] tg, input logic cl, input logic rt, input logic hl);
        startI   = s;
        stallI   = st;
        brEnI    = br;
        brRelI   = rel;
        targetI  = tg;
        callEnI  = cl;
        retEnI   = rt;
        haltReqI = hl;
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
        startI   = 1'b0;
        stallI   = 1'b0;
        brEnI    = 1'b0;
        brRelI   = 1'b0;
        targetI  = '0;
        callEnI  = 1'b0;
        retEnI   = 1'b0;
        haltReqI = 1'b0;
    endtask

    task automatic idleTicks(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, 0, 0, 0);
    endtask

    task automatic doStart();
        applyStimulus(1, 0, 0, 0, '0, 0, 0, 0);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        checkEn = 1'b0;
        reset = 1'b1;
        startI = 0; stallI = 0; brEnI = 0; brRelI = 0; targetI = '0;
        callEnI = 0; retEnI = 0; haltReqI = 0;
        modelReset();
        #12;
        compareVal("reset prog_ctr", int'(progCtr), 0);
        compareVal("reset running", int'(runningO), 0);
        compareVal("reset done", int'(doneO), 0);
        compareVal("reset stk_err", int'(stkErrO), 0);
        @(negedge clk);
        reset = 1'b0;
        checkEn = 1'b1;

        // IDLE ignores everything except start.
        applyStimulus(0, 0, 1, 0, 10'd77, 1, 0, 0);
        compareVal("idle ignores branch", int'(progCtr), 0);

        // Reset/start: run to 37, then reset asynchronously mid-cycle.
        doStart();
        idleTicks(37);
        compareVal("pc reached 37", int'(progCtr), 37);
        #2 reset = 1'b1;
        #1;
        compareVal("async reset prog_ctr", int'(progCtr), 0);
        compareVal("async reset running", int'(runningO), 0);
        compareVal("async reset done", int'(doneO), 0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        doStart();
        compareVal("start pc", int'(progCtr), 0);
        compareVal("start running", int'(runningO), 1);
        for (int i = 1; i <= 3; i++) begin
            idleTicks(1);
            compareVal("post-start increment", int'(progCtr), i);
        end

        // Branch + stall.
        idleTicks(2);
        compareVal("pc at 5", int'(progCtr), 5);
        applyStimulus(0, 0, 1, 0, 10'd100, 0, 0, 0);
        compareVal("abs branch", int'(progCtr), 100);
        applyStimulus(0, 0, 1, 1, 10'h3FE, 0, 0, 0);
        compareVal("rel branch -2", int'(progCtr), 98);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 10'd500, 0, 0, 0);
        compareVal("stall holds", int'(progCtr), 98);

        // Call/return with nesting, then underflow.
        applyStimulus(0, 0, 1, 0, 10'd10, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 10'd200, 1, 0, 0);
        compareVal("call 200", int'(progCtr), 200);
        idleTicks(5);
        applyStimulus(0, 0, 0, 0, 10'd300, 1, 0, 0);
        compareVal("call 300", int'(progCtr), 300);
        applyStimulus(0, 0, 0, 0, '0, 0, 1, 0);
        compareVal("ret to 206", int'(progCtr), 206);
        applyStimulus(0, 0, 0, 0, '0, 0, 1, 0);
        compareVal("ret to 11", int'(progCtr), 11);
        applyStimulus(0, 0, 0, 0, '0, 0, 1, 0);
        compareVal("underflow stk_err", int'(stkErrO), 1);
        compareVal("underflow done", int'(doneO), 1);
        compareVal("underflow pc", int'(progCtr), 11);

        // Overflow on the fifth call, then recovery via start.
        doStart();
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 10'd20, 1, 0, 0);
        compareVal("overflow stk_err", int'(stkErrO), 1);
        compareVal("overflow pc", int'(progCtr), 20);
        doStart();
        compareVal("restart pc", int'(progCtr), 0);
        compareVal("restart stk_err", int'(stkErrO), 0);

        // End of program at the top of the address space.
        applyStimulus(0, 0, 1, 0, 10'd1022, 0, 0, 0);
        idleTicks(1);
        compareVal("pc at 1023", int'(progCtr), 1023);
        compareVal("running at 1023", int'(runningO), 1);
        idleTicks(1);
        compareVal("eop done", int'(doneO), 1);
        compareVal("eop pc", int'(progCtr), 1023);
        idleTicks(1);
        compareVal("halt holds pc", int'(progCtr), 1023);

        // Priority: halt beats ret/call/branch; stack stays as it was.
        doStart();
        applyStimulus(0, 0, 0, 0, 10'd50, 1, 0, 0);
        compareVal("call to 50", int'(progCtr), 50);
        applyStimulus(0, 0, 1, 0, 10'd7, 1, 1, 1);
        compareVal("priority done", int'(doneO), 1);
        compareVal("priority pc", int'(progCtr), 50);
        compareVal("priority stk_err", int'(stkErrO), 0);
        compareVal("model stack depth", mStack.size(), 1);

        // Randomized requests; restart whenever the core has stopped.
        for (int i = 0; i < 3000; i++) begin
            logic s, st, br, rel, cl, rt, hl;
            logic [D-1:0] tg;
            s   = (mMode != 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            st  = ($urandom_range(0, 7) == 0);
            br  = ($urandom_range(0, 3) == 0);
            rel = $urandom_range(0, 1) == 1;
            cl  = ($urandom_range(0, 7) == 0);
            rt  = ($urandom_range(0, 7) == 0);
            hl  = ($urandom_range(0, 99) == 0);
            tg  = D'($urandom_range(0, M - 1));
            if ($urandom_range(0, 15) == 0) tg = '1;
            applyStimulus(s, st, br, rel, tg, cl, rt, hl);
        end

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
